piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out shifter; successor to the fixed 4-bit PISO.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out MSB-first or LSB-first, one bit per shift_en pulse, with frame-valid and last-bit flags.
- Back-to-back words produce a gapless serial stream.
- Sits between a parallel producer (register file, FIFO) and a serial line driver or baud-tick-paced link.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_stream.sv | 85 ++++++++
 tb/tb_piso_stream.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out stream shifter.
//   state_t   : two-state FSM encoding (IDLE / SHIFT), built on ST_IDLE / ST_SHIFT.
//   cnt_width : bit-counter width for a given word length (clog2, never below 1).
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  // Counter must hold WIDTH-1; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_stream.sv
// Parametrised parallel-in/serial-out shifter with a valid/ready load port.
// A WIDTH-bit word is accepted, then shifted out one bit per shift_en pulse,
// MSB-first (MSB_FIRST=1) or LSB-first (MSB_FIRST=0). A word offered while the
// last bit is being shifted is loaded on that same edge, so consecutive words
// form a gapless stream.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_data   in   [WIDTH-1:0] parallel word
//   in_valid  in   producer offers in_data
//   in_ready  out  word accepted this cycle (combinational, 0 during reset)
//   shift_en  in   bit-advance strobe
//   ser_out   out  current serial bit
//   ser_valid out  ser_out carries a frame bit
//   ser_last  out  ser_out is the final bit of the word
//   busy      out  frame in progress; mirrors the FSM state (1 = SHIFT)
//
// Load handshake: a word transfers on any rising edge where in_valid and
// in_ready are both 1. in_valid may be raised at any time; while in_ready is 0
// the producer holds in_data and in_valid unchanged.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam int             OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             load;

  assign at_last  = (state == SHIFT) && (cnt == '0);
  // Ready in IDLE, or while the final bit is being consumed, which lets the
  // next word follow without an idle cycle.
  assign in_ready = rst_n && ((state == IDLE) || (at_last && shift_en));
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (load) begin
      sreg  <= in_data;
      cnt   <= CNT_LAST;
      state <= SHIFT;
    end else if ((state == SHIFT) && shift_en) begin
      if (cnt != '0) begin
        // Move the next bit toward the output end, zero-fill behind it.
        if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
        else           sreg <= {1'b0, sreg[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
      end else begin
        // Word done with nothing queued: clear so ser_out returns to 0.
        state <= IDLE;
        sreg  <= '0;
      end
    end
  end

  // sreg is all-zero whenever the FSM is IDLE, so ser_out needs no gating.
  assign ser_out   = sreg[OUT_BIT];
  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign ser_last  = at_last;

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

  logic       clk;
  logic       rst_n;
  logic [7:0] din8;
  logic       vld8;
  logic       sen8;
  logic [3:0] din4;
  logic       vld4;
  logic       sen4;

  logic rdy_m, out_m, val_m, last_m, busy_m;
  logic rdy_l, out_l, val_l, last_l, busy_l;
  logic rdy_4, out_4, val_4, last_4, busy_4;

  int total;
  int bad;

  logic [0:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(din8), .in_valid(vld8), .in_ready(rdy_m),
    .shift_en(sen8), .ser_out(out_m), .ser_valid(val_m), .ser_last(last_m), .busy(busy_m)
  );

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(din8), .in_valid(vld8), .in_ready(rdy_l),
    .shift_en(sen8), .ser_out(out_l), .ser_valid(val_l), .ser_last(last_l), .busy(busy_l)
  );

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_4 (
    .clk(clk), .rst_n(rst_n), .in_data(din4), .in_valid(vld4), .in_ready(rdy_4),
    .shift_en(sen4), .ser_out(out_4), .ser_valid(val_4), .ser_last(last_4), .busy(busy_4)
  );

  // driver: advance one clock, land 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din8 = '0; vld8 = 1'b0; sen8 = 1'b0;
    din4 = '0; vld4 = 1'b0; sen4 = 1'b0;
    step(); step();
    #1;
    total++;
    if ({out_m, val_m, last_m, busy_m, rdy_m} !== 5'b0) begin
      bad++; $display("FAIL reset_m got=%b exp=00000", {out_m, val_m, last_m, busy_m, rdy_m});
    end
    total++;
    if ({out_l, val_l, last_l, rdy_l, out_4, val_4, last_4, rdy_4} !== 8'b0) begin
      bad++; $display("FAIL reset_l4 got=%b exp=00000000",
                      {out_l, val_l, last_l, rdy_l, out_4, val_4, last_4, rdy_4});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (rdy_m !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rdy_m); end
  endtask

  // 8'hC1 through the MSB-first and LSB-first instances together
  task automatic test_bit_order();
    logic [7:0] em;
    logic [7:0] el;
    em = 8'b11000001;  // MSB-first stream, first bit at [7]
    el = 8'b10000011;  // LSB-first stream, first bit at [7]
    din8 = 8'hC1; vld8 = 1'b1; sen8 = 1'b1;
    step();
    vld8 = 1'b0; din8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (out_m !== em[7-i] || val_m !== 1'b1 || busy_m !== 1'b1) begin
        bad++; $display("FAIL msb_bit%0d got out=%b val=%b exp out=%b val=1", i, out_m, val_m, em[7-i]);
      end
      total++;
      if (out_l !== el[7-i] || val_l !== 1'b1) begin
        bad++; $display("FAIL lsb_bit%0d got out=%b val=%b exp out=%b val=1", i, out_l, val_l, el[7-i]);
      end
      total++;
      if (last_m !== (i == 7) || rdy_m !== (i == 7)) begin
        bad++; $display("FAIL msb_last%0d got last=%b rdy=%b exp=%b", i, last_m, rdy_m, (i == 7));
      end
      step();
    end
    #1;
    total++;
    if ({val_m, out_m, last_m, val_l, out_l} !== 5'b0) begin
      bad++; $display("FAIL order_end got=%b exp=00000", {val_m, out_m, last_m, val_l, out_l});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic [7:0] w1;
    logic [0:0] e;
    w0 = 8'h0F; w1 = 8'hF0;
    for (int b = 7; b >= 0; b--) exp_q.push_back(w0[b]);
    for (int b = 7; b >= 0; b--) exp_q.push_back(w1[b]);
    din8 = w0; vld8 = 1'b1; sen8 = 1'b1;
    step();
    din8 = w1;  // in-flight frame must ignore this change
    for (int i = 0; i < 16; i++) begin
      #1;
      e = exp_q.pop_front();
      total++;
      if (out_m !== e[0] || val_m !== 1'b1) begin
        bad++; $display("FAIL b2b_bit%0d got out=%b val=%b exp out=%b val=1", i, out_m, val_m, e[0]);
      end
      total++;
      if (last_m !== (i == 7 || i == 15)) begin
        bad++; $display("FAIL b2b_last%0d got=%b exp=%b", i, last_m, (i == 7 || i == 15));
      end
      step();
      if (i == 7) vld8 = 1'b0;
    end
    #1;
    total++;
    if (val_m !== 1'b0) begin bad++; $display("FAIL b2b_end got val=%b exp=0", val_m); end
  endtask

  task automatic test_throttle();
    logic [7:0] ea;
    ea = 8'b10100101;
    din8 = 8'hA5; vld8 = 1'b1; sen8 = 1'b1;
    step();
    vld8 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      sen8 = (k % 3 == 2);
      #1;
      total++;
      if (out_m !== ea[7 - k/3] || val_m !== 1'b1 || last_m !== (k/3 == 7)) begin
        bad++; $display("FAIL thr_cyc%0d got out=%b val=%b last=%b exp out=%b val=1 last=%b",
                        k, out_m, val_m, last_m, ea[7 - k/3], (k/3 == 7));
      end
      step();
    end
    #1;
    total++;
    if (val_m !== 1'b0) begin bad++; $display("FAIL thr_end got val=%b exp=0", val_m); end
    sen8 = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e8;
    e8 = 8'b10000001;
    din8 = 8'hFF; vld8 = 1'b1; sen8 = 1'b1;
    step();
    vld8 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    // reset coincides with an offered word: reset must win
    rst_n = 1'b0; din8 = 8'h81; vld8 = 1'b1;
    #1;
    total++;
    if (rdy_m !== 1'b0) begin bad++; $display("FAIL rst_ready_low got=%b exp=0", rdy_m); end
    step();
    #1;
    total++;
    if ({val_m, out_m, last_m, busy_m} !== 4'b0) begin
      bad++; $display("FAIL rst_abort got=%b exp=0000", {val_m, out_m, last_m, busy_m});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (rdy_m !== 1'b1) begin bad++; $display("FAIL rst_ready_high got=%b exp=1", rdy_m); end
    step();
    vld8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (out_m !== e8[7-i] || val_m !== 1'b1 || last_m !== (i == 7)) begin
        bad++; $display("FAIL rst_reload_bit%0d got out=%b val=%b last=%b exp out=%b", i, out_m, val_m, last_m, e8[7-i]);
      end
      step();
    end
  endtask

  task automatic test_width4();
    logic [3:0] e4;
    e4 = 4'b1011;
    vld4 = 1'b0; sen4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      total++;
      if (val_4 !== 1'b0 || out_4 !== 1'b0) begin
        bad++; $display("FAIL w4_idle%0d got val=%b out=%b exp val=0 out=0", i, val_4, out_4);
      end
    end
    din4 = 4'b1011; vld4 = 1'b1;
    step();
    vld4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (out_4 !== e4[3-i] || val_4 !== 1'b1 || last_4 !== (i == 3)) begin
        bad++; $display("FAIL w4_bit%0d got out=%b val=%b last=%b exp out=%b last=%b",
                        i, out_4, val_4, last_4, e4[3-i], (i == 3));
      end
      step();
    end
    #1;
    total++;
    if (val_4 !== 1'b0) begin bad++; $display("FAIL w4_end got val=%b exp=0", val_4); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_throttle();
    test_reset_mid_frame();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
